// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential 4-to-2 encoder.
// Holds the FSM state type, request/index widths and a popcount helper.
package enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/encoder4to2_es_prio_sel4.sv
// Picks one set bit of a 4-bit pending vector: highest index in fixed mode,
// or the first set bit at or after ptr (wrapping) in round-robin mode.
module prio_sel4
  import enc_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W-1:0] w_probe;

  // Later loop iterations overwrite earlier hits, so loop order sets priority.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_probe = '0;
    if (!RR) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_pending[i]) begin
          o_idx   = IDX_W'(i);
          o_found = 1'b1;
        end
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        w_probe = i_ptr + IDX_W'(k);
        if (i_pending[w_probe]) begin
          o_idx   = w_probe;
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encoder4to2_es.sv
// Sequential 4-to-2 encoder: pends normalised request lines and presents
// them one at a time as a binary index over a valid/ready handshake.
module encoder4to2_es
  import enc_pkg::*;
#(
  parameter bit RR   = 1'b0,
  parameter bit EDGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] y,
  input  logic             S,
  input  logic             En,
  input  logic             w_ready,
  output logic [IDX_W-1:0] w,
  output logic             w_valid,
  output logic             any_pending,
  output logic             multi_hot
);

  state_t           r_state;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_aQ;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_w;
  logic             r_wValid;
  logic             r_anyPending;
  logic             r_multiHot;

  logic [N_REQ-1:0] w_a;
  logic [N_REQ-1:0] w_cap;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_pendNext;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  prio_sel4 #(.RR(RR)) u_sel (
    .i_pending(r_pending),
    .i_ptr    (r_ptr),
    .o_idx    (w_idx),
    .o_found  (w_found)
  );

  // Set wins over clear, so a held level request re-pends right after its grant.
  always_comb begin
    w_a        = En ? (S ? ~y : y) : '0;
    w_cap      = EDGE ? (w_a & ~r_aQ) : w_a;
    w_clr      = (r_state == IDLE && w_found) ? (N_REQ'(1) << w_idx) : '0;
    w_pendNext = (r_pending & ~w_clr) | w_cap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_aQ         <= '0;
      r_ptr        <= '0;
      r_w          <= '0;
      r_wValid     <= 1'b0;
      r_anyPending <= 1'b0;
      r_multiHot   <= 1'b0;
    end else begin
      r_pending    <= w_pendNext;
      r_aQ         <= w_a;
      r_anyPending <= |w_pendNext;
      if (popcount4(w_a) >= 3'd2) begin
        r_multiHot <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_w      <= w_idx;
            r_wValid <= 1'b1;
            r_state  <= PRESENT;
            if (RR) begin
              r_ptr <= w_idx + IDX_W'(1);
            end
          end
        end
        PRESENT: begin
          if (w_ready) begin
            r_wValid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w           = r_w;
  assign w_valid     = r_wValid;
  assign any_pending = r_anyPending;
  assign multi_hot   = r_multiHot;

endmodule

// File: doc/encoder4to2_es.md
Name: encoder4to2_es

Overview:
- Sequential 4-to-2 encoder: the inverse of our 2-to-4 decoder with enable (En) and polarity select (S).
- Captures request lines y[3:0] into a pending register and emits each pending request, one at a time, as a 2-bit code w[1:0].
- Output uses a valid/ready handshake.
- Sits between a one-hot/multi-hot request source (or a decoder output) and a consumer that needs binary indices, e.g. an interrupt-style encoder.

Parameters:
- RR, 0: arbitration mode. 0 = fixed priority (bit 3 highest); 1 = round-robin.
- EDGE, 0: capture mode. 0 = level (a bit is pended every cycle it is active); 1 = rising-edge (a bit is pended only on an inactive->active transition).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- y  input  4  request lines.
- S  input  1  polarity. 0 = requests active-high; 1 = requests active-low (same sense as the decoder S).
- En  input  1  capture enable. 0 blocks new captures.
- w_ready  input  1  consumer ready.
- w  output  2  encoded index.
- w_valid  output  1  w holds a valid code.
- any_pending  output  1  pending register non-zero (registered).
- multi_hot  output  1  sticky flag: more than one request was active in the same cycle.

Behaviour:
- Reset: rst is asynchronous. While rst=1:
  - pending=0, a_q=0, ptr=0, state=IDLE.
  - w=2'b00, w_valid=0, any_pending=0, multi_hot=0.
  - Deassertion is sampled synchronously; the first capture occurs on the first clk edge with rst=0.
- Normalisation (combinational): a = En ? (S ? ~y : y) : 4'b0000.
- Capture mask:
  - EDGE=0: cap = a.
  - EDGE=1: cap = a & ~a_q, where a_q is a registered every cycle.
- Pending update, every edge: pending <= (pending & ~clr) | cap.
  - clr is one-hot for the granted bit, otherwise 0.
  - Set has priority over clear on the same bit: a held level request re-pends immediately.
- multi_hot: set on any edge where popcount(a) >= 2. Cleared only by rst.
- any_pending: registered copy of (next pending != 0).
- FSM, two states:
  - IDLE: if pending != 0, select idx, then w <= idx, w_valid <= 1, clr = onehot(idx), go PRESENT. Otherwise stay in IDLE with w_valid=0 and w holding its last value.
  - PRESENT: w and w_valid are held stable. If w_ready=1 on an edge, w_valid <= 0 and go IDLE. Otherwise stay.
- Selection:
  - RR=0: highest set bit of pending (3 > 2 > 1 > 0).
  - RR=1: first set bit searching ptr, ptr+1, ... with mod-4 wrap. On grant, ptr <= idx+1 (2-bit natural wrap, 3 -> 0).
- Latency:
  - Request active at edge k -> pending set after edge k -> w_valid=1 after edge k+1.
  - Handshake completes on an edge with w_valid & w_ready. The next grant comes one edge later, so there is one IDLE bubble and at most one code per 2 cycles.
- En=0: no new captures. Already-pending requests continue to be served.
- S change mid-stream: takes effect in the same cycle's normalisation. In EDGE=1 mode a polarity flip can create edges; this is legal behaviour.
- Mid-operation reset: all state is lost immediately and w_valid drops asynchronously.

Decomposition:
- Shared package enc_pkg:
  - state typedef {IDLE, PRESENT}.
  - localparam N_REQ=4, IDX_W=2.
  - function popcount4.
- One natural sub-module, prio_sel4: combinational pending + ptr + RR -> idx, found. It is reused by the fixed and round-robin paths.

Test Plan:
- Reset/idle: assert rst mid-PRESENT -> w_valid=0, w=0, any_pending=0 immediately; with y=0 for 10 cycles after release -> w_valid stays 0.
- Fixed priority, S=0, En=1, EDGE=0, RR=0: y=4'b1010 pulsed for 1 cycle, w_ready=1 -> codes w=3 then w=1, each with w_valid for 1 cycle, 1-cycle bubble between; multi_hot=1.
- Polarity/enable: S=1, y=4'b1011, En=1 for 1 cycle -> single code w=2 and multi_hot stays 0. Same stimulus with En=0 -> no w_valid.
- Backpressure: y=4'b0001 single pulse, w_ready=0 for 5 cycles -> w=0, w_valid=1 held stable all 5 cycles; w_ready=1 -> w_valid=0 next edge, any_pending=0.
- Round-robin, RR=1, EDGE=0: y=4'b1111 held, w_ready=1 -> w sequence 0,1,2,3,0,1 (wrap verified), pending never empties, any_pending=1.
- Edge mode, EDGE=1: y=4'b0100 held 20 cycles -> exactly one w=2 grant; deassert then reassert -> one more grant.
